// File: rtl/subtrator_serial_8bits.sv
// Bit-serial subtractor D = A - B - Bin, one bit per clock LSB first, with a
// start/busy/done handshake and borrow/overflow/zero flags.

module subtrator_serial_fs_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module subtrator_serial_8bits #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ra, rb, sr, sr_nxt;
  logic             br, a_msb, b_msb;
  logic [CW-1:0]    cnt;
  logic             d_bit, bo_bit;
  logic             load, last;

  subtrator_serial_fs_cell u_cell (
    .a  (ra[0]),
    .b  (rb[0]),
    .bi (br),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // Result bits enter at the top, so after WIDTH shifts bit 0 sits at the LSB.
  assign sr_nxt = {d_bit, sr[WIDTH-1:1]};
  assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      Bout  <= 1'b0;
      V     <= 1'b0;
      Z     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        ra    <= A;
        rb    <= B;
        br    <= Bin;
        a_msb <= A[WIDTH-1];
        b_msb <= B[WIDTH-1];
        cnt   <= '0;
        sr    <= '0;
      end else if (state == SHIFT) begin
        br <= bo_bit;
        sr <= sr_nxt;
        ra <= ra >> 1;
        rb <= rb >> 1;
        // Counter stops at WIDTH-1 on the completion edge instead of wrapping.
        if (last) begin
          D    <= sr_nxt;
          Bout <= bo_bit;
          V    <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
          Z    <= ~|sr_nxt;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_subtrator_serial_8bits.sv
// Randomized scoreboard bench for subtrator_serial_8bits: issue side pushes
// arithmetic-model results, a negedge monitor pops them on every done pulse.

module tb_subtrator_serial_8bits;

  logic       clk = 1'b0;
  logic       rst_n, start, Bin;
  logic [7:0] A, B;
  logic [7:0] D;
  logic       Bout, V, Z, busy, done;

  typedef struct {
    logic [7:0] d;
    logic       bout;
    logic       v;
    logic       z;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] hold_d = 8'h00;

  always #5 clk = ~clk;

  subtrator_serial_8bits dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .D     (D),
    .Bout  (Bout),
    .V     (V),
    .Z     (Z),
    .busy  (busy),
    .done  (done)
  );

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t r;
    int   ud, sd;
    ud     = int'(a) - int'(b) - int'(bin);
    sd     = int'($signed(a)) - int'($signed(b)) - int'(bin);
    r.d    = ud[7:0];
    r.bout = (ud < 0);
    r.v    = (sd < -128) || (sd > 127);
    r.z    = (r.d == 8'h00);
    return r;
  endfunction

  // Monitor: scoreboard pop on done, hold check while busy, exclusivity.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_excl: busy=%b done=%b, required not both high", busy, done);
      end
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done pulse with no operation outstanding");
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (D !== e.d || Bout !== e.bout || V !== e.v || Z !== e.z) begin
            errors++;
            $display("FAIL result: got D=%h Bout=%b V=%b Z=%b, required D=%h Bout=%b V=%b Z=%b",
                     D, Bout, V, Z, e.d, e.bout, e.v, e.z);
          end
          hold_d = e.d;
        end
      end
      if (busy) begin
        checks++;
        if (D !== hold_d) begin
          errors++;
          $display("FAIL hold_d: D=%h while busy, required %h", D, hold_d);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy=%b after 40 cycles, required 0", busy);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bin);
    wait_idle();
    A = a; B = b; Bin = bin; start = 1'b1;
    sb.push_back(model(a, b, bin));
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom; Bin = $urandom;  // post-acceptance changes must not matter
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy || done) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({D, Bout, V, Z, busy, done} !== 13'h0) begin
      errors++;
      $display("FAIL reset_state: D=%h Bout=%b V=%b Z=%b busy=%b done=%b, required all 0",
               D, Bout, V, Z, busy, done);
    end

    // Latency: 8 busy cycles then a single done cycle.
    issue(8'd100, 8'd50, 1'b0);
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 8 || done !== 1'b1) begin
      errors++;
      $display("FAIL latency: busy_cycles=%0d done=%b, required 8 and 1", n, done);
    end
    drain();

    issue(8'h00, 8'h01, 1'b0);
    issue(8'h80, 8'h01, 1'b0);
    issue(8'h7F, 8'hFF, 1'b0);
    issue(8'h10, 8'h0F, 1'b1);
    issue(8'hFF, 8'hFF, 1'b1);
    issue(8'h80, 8'h00, 1'b1);
    drain();

    // Start while busy is ignored.
    issue(8'h05, 8'h03, 1'b0);
    @(posedge clk); #1;
    A = 8'h00; B = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // Back-to-back: start held through DONE reloads with no IDLE cycle.
    wait_idle();
    A = 8'h20; B = 8'h05; Bin = 1'b0; start = 1'b1;
    sb.push_back(model(8'h20, 8'h05, 1'b0));
    @(posedge clk); #1;
    A = 8'h33; B = 8'h11; Bin = 1'b1;
    sb.push_back(model(8'h33, 8'h11, 1'b1));
    n = 0;
    @(negedge clk);
    while (!done && n < 30) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: busy=%b after DONE with start held, required 1", busy);
    end
    start = 1'b0;
    drain();

    // Mid-operation reset abandons the operation.
    issue(8'hAA, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    hold_d = 8'h00;
    rst_n = 1'b1;
    checks++;
    if ({D, Bout, V, Z, busy, done} !== 13'h0) begin
      errors++;
      $display("FAIL mid_reset: D=%h Bout=%b V=%b Z=%b busy=%b done=%b, required all 0",
               D, Bout, V, Z, busy, done);
    end
    repeat (12) @(posedge clk);
    issue(8'h03, 8'h01, 1'b0);
    drain();

    for (int i = 0; i < 40; i++) issue(8'($urandom), 8'($urandom), 1'($urandom));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/subtrator_serial_8bits.md
Name: subtrator_serial_8bits

Overview:
- Bit-serial, multi-cycle subtractor computing D = A − B − Bin. It is the inverse-direction counterpart of the parallel ripple adder datapath.
- It processes one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- It sits beside the adder in the arithmetic unit, where area matters more than latency.
- Uses a start/busy/done handshake and reports borrow, signed-overflow and zero flags.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- CW, 4, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only when not busy.
- A  input  WIDTH  minuend; latched on accepted start.
- B  input  WIDTH  subtrahend; latched on accepted start.
- Bin  input  1  borrow-in; latched on accepted start.
- D  output  WIDTH  difference (A − B − Bin) mod 2^WIDTH.
- Bout  output  1  borrow-out; 1 when A < B + Bin (unsigned).
- V  output  1  two's-complement overflow.
- Z  output  1  1 when D == 0.
- busy  output  1  high while shifting.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low.
- Reset values: when rst_n = 0 at an edge, state ← IDLE, and D, Bout, V, Z, busy, done, the counter and all internal registers ← 0. This applies identically mid-operation; any operation in flight is abandoned and never signals done.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy = 0, done = 0.
  - start = 1 at an edge: latch A→ra, B→rb, Bin→br, clear counter, clear shift register sr, go to SHIFT.
- SHIFT (busy = 1, done = 0), at each edge:
  - d = ra[0] ^ rb[0] ^ br.
  - br ← (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br).
  - sr ← {d, sr[WIDTH−1:1]}; ra and rb shift right by 1; counter ← counter + 1.
  - On the edge where counter == WIDTH−1:
    - D ← final sr (including this cycle's d) and Bout ← final br.
    - V ← (A_msb ^ B_msb) & (D_msb ^ A_msb), using the latched original operand MSBs (keep copies).
    - Z ← (final D == 0); go to DONE.
- DONE:
  - busy = 0, done = 1 for exactly one cycle.
  - With start = 1: accepted as a new load, back-to-back, go to SHIFT.
  - Otherwise go to IDLE.
- Latency: accepted start at edge k → done high in the cycle after edge k+WIDTH (8 cycles at the default width).
- Throughput: one result per WIDTH+1 cycles with continuous start.
- start while busy = 1 is ignored; nothing is queued.
- A, B and Bin changes after acceptance have no effect.
- D, Bout, V and Z change only on the completion edge (or reset). They hold the previous result through IDLE and SHIFT until the next completion.
- Wrap-around: D is always modulo 2^WIDTH; underflow is indicated only by Bout = 1.
- busy and done are never high simultaneously.
- RTL: purely synchronous; no latches; the counter saturates never beyond WIDTH−1.

Test Plan:
- Reset, then A=100, B=50, Bin=0, start 1 cycle → busy for 8 cycles, then done pulse; D=50, Bout=0, V=0, Z=0.
- A=0x00, B=0x01, Bin=0 → D=0xFF, Bout=1, V=0, Z=0.
- A=0x80, B=0x01, Bin=0 → D=0x7F, Bout=0, V=1. Then A=0x7F, B=0xFF → D=0x80, Bout=1, V=1.
- A=0x10, B=0x0F, Bin=1 → D=0x00, Z=1, Bout=0. Previous D is held unchanged during the 8 busy cycles.
- start pulsed with A=0x05, B=0x03; at cycle 3, pulse start with A=0x00, B=0xFF (ignored) → D=0x02. Then start held high through DONE → second operation begins with no IDLE cycle.
- Start A=0xAA, B=0x55; drive rst_n=0 at cycle 4 for one edge → all outputs 0, no done pulse. The next operation, 0x03 − 0x01, gives D=0x02.
